dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Posted-write buffer between the processor's data-memory port (o_addr / o_dmem / o_wmem, i_dmem) and the data-memory bus. Core stores enter a small FIFO in one cycle and drain to memory over a req/ack handshake, so the core does not wait on slow memory. Core loads see the newest buffered data via address-match forwarding; on a miss they see memory's combinational read data. A stall output back-pressures the core only when a store arrives while the FIFO is full.

## Interface

- DEPTH, 4, number of buffer entries; power of two, ≥ 2
- i_clk  in  1  clock; all state updates on rising edge
- i_resetn  in  1  synchronous, active-low reset
- i_core_addr  in  32  core data address; bits [1:0] ignored (word accesses only)
- i_core_wdata  in  32  core store data
- i_core_wmem  in  1  core store strobe, one store per cycle while high
- o_core_rdata  out  32  load data to core (combinational)
- o_core_stall  out  1  store not accepted this cycle; core must hold the store
- o_mem_raddr  out  32  memory read address; equals i_core_addr (combinational)
- i_mem_rdata  in  32  memory combinational read data for o_mem_raddr
- o_mem_req  out  1  head entry valid, write pending
- o_mem_addr  out  32  head entry address, with bits [1:0] forced to 0
- o_mem_wdata  out  32  head entry data
- i_mem_ack  in  1  memory accepted the head write this cycle
- o_count  out  $clog2(DEPTH)+1  current number of valid entries
- o_empty  out  1  o_count == 0; used as the store fence

## Operation

- Storage: circular FIFO of DEPTH entries {addr[31:2], data}, head/tail pointers $clog2(DEPTH) bits wide that wrap modulo DEPTH, and a count register.
- drain = o_mem_req & i_mem_ack. When drain is high, the head is removed at the edge. i_mem_ack while o_mem_req=0 is ignored.
- accept = i_core_wmem & (count < DEPTH | drain). A full buffer still accepts a store in the same cycle its head drains.
- o_core_stall = i_core_wmem & ~accept. This output is purely combinational and never asserts when i_core_wmem=0.
- Count update:
  - accept & drain: unchanged
  - accept only: +1
  - drain only: −1
- Head outputs:
  - o_mem_req = (count != 0).
  - o_mem_addr and o_mem_wdata come from the head entry and stay stable while o_mem_req=1 and i_mem_ack=0.
  - When count = 0, o_mem_addr and o_mem_wdata are 0.
- Load forwarding (combinational):
  - Compare i_core_addr[31:2] against every valid entry.
  - On one or more matches, o_core_rdata = data of the youngest matching entry (closest to tail). Otherwise o_core_rdata = i_mem_rdata.
  - An entry being drained this cycle still participates in forwarding.
  - A store being accepted this cycle does not participate.
- Duplicate addresses are kept as separate entries, with no write merging. They drain in program order.
- Reset (i_resetn=0 at an edge): count, head and tail go to 0, and all pending writes are discarded. The entry array is not cleared. Reset overrides accept and drain in the same cycle.
- Reset values: o_mem_req=0, o_count=0, o_empty=1, o_mem_addr=0, o_mem_wdata=0. o_core_stall follows its combinational equation, which gives 0 with i_core_wmem=0.

## Timing

- Store latency: a store accepted at edge N gives o_mem_req=1 and is forwardable after edge N. There is no bypass, so o_mem_req is never high in the cycle the store is presented.
- Drain throughput: one entry per cycle while i_mem_ack is held high.
- Memory may hold i_mem_ack low for any number of cycles. The head holds until ack.
- o_core_stall, o_core_rdata and o_mem_raddr have zero-cycle (combinational) paths from core inputs. The core samples them in the same cycle.
- Full boundary:
  - count = DEPTH, store, no ack: stall=1, and count stays at DEPTH.
  - count = DEPTH, store with ack: stall=0, and count stays at DEPTH.
- Empty boundary: count = 0 with ack: no change, o_mem_req stays 0.

## Test plan

- Reset, then store 0xA5A5_0001 to 0x100 with i_mem_ack=0:
  - next cycle: o_mem_req=1, o_mem_addr=0x100, o_count=1
  - a load from 0x100 (and from 0x103) returns 0xA5A5_0001 while i_mem_rdata=0xDEAD_BEEF
  - a load from 0x104 returns 0xDEAD_BEEF
- Store 0x11 then 0x22 to 0x200, ack held low:
  - a load from 0x200 returns 0x22
  - after one ack, a load still returns 0x22
  - the head order on the bus is 0x11 then 0x22
- Fill DEPTH=4 with no ack, then a fifth store:
  - o_core_stall=1 and o_count=4
  - same fifth store with i_mem_ack=1: stall=0, o_count stays 4, and the oldest entry leaves
- Four stores back-to-back with i_mem_ack tied high:
  - o_mem_req is high for 4 consecutive cycles starting 1 cycle after the first store
  - addresses appear in order, and o_empty=1 afterwards
- Reset asserted with 3 entries pending and ack high:
  - after the edge, o_count=0, o_mem_req=0, o_empty=1
  - loads return i_mem_rdata
- Pulse i_mem_ack with buffer empty: no state change, o_count=0. Push more than DEPTH entries in total to confirm pointer wrap-around keeps FIFO order.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and the data-memory bus.
// Stores queue in a circular FIFO and drain over req/ack; loads forward from the youngest matching entry.
module dmem_store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_resetn,
   input  logic [31:0]                i_core_addr,
   input  logic [31:0]                i_core_wdata,
   input  logic                       i_core_wmem,
   output logic [31:0]                o_core_rdata,
   output logic                       o_core_stall,
   output logic [31:0]                o_mem_raddr,
   input  logic [31:0]                i_mem_rdata,
   output logic                       o_mem_req,
   output logic [31:0]                o_mem_addr,
   output logic [31:0]                o_mem_wdata,
   input  logic                       i_mem_ack,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [29:0]   addr_q [DEPTH];
   logic [29:0]   addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];

   logic full;
   logic nonempty;
   logic drain;
   logic accept;

   assign full     = (count_q == CW'(DEPTH));
   assign nonempty = (count_q != '0);
   assign drain    = nonempty & i_mem_ack;
   // A full buffer still takes a store when its head leaves in the same cycle.
   assign accept   = i_core_wmem & (~full | drain);

   assign o_core_stall = i_core_wmem & ~accept;
   assign o_mem_raddr  = i_core_addr;
   assign o_mem_req    = nonempty;
   assign o_mem_addr   = nonempty ? {addr_q[head_q], 2'b00} : '0;
   assign o_mem_wdata  = nonempty ? data_q[head_q] : '0;
   assign o_count      = count_q;
   assign o_empty      = ~nonempty;

   // Walk oldest to youngest so the last hit (closest to tail) wins.
   always_comb begin
      logic [PW-1:0] idx;
      o_core_rdata = i_mem_rdata;
      idx          = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == i_core_addr[31:2])) begin
            o_core_rdata = data_q[idx];
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (accept) begin
         addr_d[tail_q] = i_core_addr[31:2];
         data_d[tail_q] = i_core_wdata;
         tail_d         = tail_q + PW'(1);
      end
      if (drain) begin
         head_d = head_q + PW'(1);
      end
      case ({accept, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is deliberately left untouched by reset; validity comes from count.
   always_ff @(posedge i_clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table followed by random traffic against a queue model.
module tb_dmem_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        resetn;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        core_wmem;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [$clog2(DEPTH):0] count;
   logic        empty;

   int n_vec = 0;
   int n_err = 0;

   dmem_store_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_core_addr  (core_addr),
      .i_core_wdata (core_wdata),
      .i_core_wmem  (core_wmem),
      .o_core_rdata (core_rdata),
      .o_core_stall (core_stall),
      .o_mem_raddr  (mem_raddr),
      .i_mem_rdata  (mem_rdata),
      .o_mem_req    (mem_req),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_ack    (mem_ack),
      .o_count      (count),
      .o_empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rstn;
      logic        wmem;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] mrd;
      logic        stall;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      int unsigned cnt;
      logic        empty;
   } vec_t;

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } ent_t;

   vec_t tbl[$];
   ent_t q[$];

   task automatic add(input logic rstn, input logic wmem, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic ack, input logic [31:0] mrd,
                      input logic stall, input logic [31:0] rdata, input logic req,
                      input logic [31:0] maddr, input logic [31:0] mwdata,
                      input int unsigned cnt, input logic emp);
      vec_t v;
      v.rstn = rstn; v.wmem = wmem; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mrd = mrd;
      v.stall = stall; v.rdata = rdata; v.req = req; v.maddr = maddr; v.mwdata = mwdata;
      v.cnt = cnt; v.empty = emp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input logic rstn, input logic wmem, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ack, input logic [31:0] mrd);
      resetn     = rstn;
      core_wmem  = wmem;
      core_addr  = addr;
      core_wdata = wdata;
      mem_ack    = ack;
      mem_rdata  = mrd;
   endtask

   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   initial begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, DB);
      repeat (2) @(posedge clk);
      #1;

      // rstn wmem addr wdata ack mrd | stall rdata req maddr mwdata cnt empty
      add(1,1,32'h100,32'hA5A5_0001,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,0,32'h100,32'h0,0,DB, 0,32'hA5A5_0001,1,32'h100,32'hA5A5_0001,1,0);
      add(1,0,32'h103,32'h0,0,DB, 0,32'hA5A5_0001,1,32'h100,32'hA5A5_0001,1,0);
      add(1,0,32'h104,32'h0,0,DB, 0,DB,1,32'h100,32'hA5A5_0001,1,0);
      add(1,0,32'h104,32'h0,1,DB, 0,DB,1,32'h100,32'hA5A5_0001,1,0);
      // duplicate addresses, youngest forwards, bus order preserved
      add(1,1,32'h200,32'h11,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,1,32'h200,32'h22,0,DB, 0,32'h11,1,32'h200,32'h11,1,0);
      add(1,0,32'h200,32'h0,1,DB, 0,32'h22,1,32'h200,32'h11,2,0);
      add(1,0,32'h200,32'h0,0,DB, 0,32'h22,1,32'h200,32'h22,1,0);
      add(1,0,32'h200,32'h0,1,DB, 0,32'h22,1,32'h200,32'h22,1,0);
      // ack on empty buffer is ignored
      add(1,0,32'h0,32'h0,1,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,0,32'h0,32'h0,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      // fill, then stall, then store-with-drain at full
      add(1,1,32'h300,32'h1,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,1,32'h304,32'h2,0,DB, 0,DB,1,32'h300,32'h1,1,0);
      add(1,1,32'h308,32'h3,0,DB, 0,DB,1,32'h300,32'h1,2,0);
      add(1,1,32'h30C,32'h4,0,DB, 0,DB,1,32'h300,32'h1,3,0);
      add(1,1,32'h310,32'h5,0,DB, 1,DB,1,32'h300,32'h1,4,0);
      add(1,1,32'h310,32'h5,1,DB, 0,DB,1,32'h300,32'h1,4,0);
      add(1,0,32'h310,32'h0,0,DB, 0,32'h5,1,32'h304,32'h2,4,0);
      add(1,0,32'h300,32'h0,0,DB, 0,DB,1,32'h304,32'h2,4,0);
      add(1,0,32'h0,32'h0,1,DB, 0,DB,1,32'h304,32'h2,4,0);
      add(1,0,32'h0,32'h0,1,DB, 0,DB,1,32'h308,32'h3,3,0);
      add(1,0,32'h0,32'h0,1,DB, 0,DB,1,32'h30C,32'h4,2,0);
      add(1,0,32'h0,32'h0,1,DB, 0,DB,1,32'h310,32'h5,1,0);
      // back-to-back stores with ack tied high
      add(1,1,32'h400,32'hA,1,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,1,32'h404,32'hB,1,DB, 0,DB,1,32'h400,32'hA,1,0);
      add(1,1,32'h408,32'hC,1,DB, 0,DB,1,32'h404,32'hB,1,0);
      add(1,1,32'h40C,32'hD,1,DB, 0,DB,1,32'h408,32'hC,1,0);
      add(1,0,32'h0,32'h0,1,DB, 0,DB,1,32'h40C,32'hD,1,0);
      add(1,0,32'h0,32'h0,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      // reset with three pending entries, ack and a store present
      add(1,1,32'h500,32'h51,0,DB, 0,DB,0,32'h0,32'h0,0,1);
      add(1,1,32'h504,32'h52,0,DB, 0,DB,1,32'h500,32'h51,1,0);
      add(1,1,32'h508,32'h53,0,DB, 0,DB,1,32'h500,32'h51,2,0);
      add(0,1,32'h50C,32'h54,1,DB, 0,DB,1,32'h500,32'h51,3,0);
      add(1,0,32'h500,32'h0,1,32'h1234_5678, 0,32'h1234_5678,0,32'h0,32'h0,0,1);
      add(1,0,32'h508,32'h0,0,32'h0BAD_F00D, 0,32'h0BAD_F00D,0,32'h0,32'h0,0,1);

      foreach (tbl[k]) begin
         drive(tbl[k].rstn, tbl[k].wmem, tbl[k].addr, tbl[k].wdata, tbl[k].ack, tbl[k].mrd);
         #3;
         chk("stall",  {31'b0, core_stall}, {31'b0, tbl[k].stall});
         chk("rdata",  core_rdata, tbl[k].rdata);
         chk("raddr",  mem_raddr,  tbl[k].addr);
         chk("req",    {31'b0, mem_req}, {31'b0, tbl[k].req});
         chk("maddr",  mem_addr,   tbl[k].maddr);
         chk("mwdata", mem_wdata,  tbl[k].mwdata);
         chk("count",  32'(count), tbl[k].cnt);
         chk("empty",  {31'b0, empty}, {31'b0, tbl[k].empty});
         @(posedge clk);
         #1;
      end

      // random traffic; the buffer is empty here, matching the empty model queue
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic        r_rstn, r_wmem, r_ack;
         logic [31:0] r_addr, r_wdata, r_mrd;
         logic        e_stall, e_accept, e_drain;
         logic [31:0] e_rdata;
         ent_t        e;
         r_rstn  = ($urandom_range(0, 199) != 0);
         r_wmem  = ($urandom_range(0, 99) < 55);
         r_ack   = ($urandom_range(0, 99) < 40);
         r_addr  = 32'h600 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
         r_wdata = $urandom;
         r_mrd   = $urandom;
         drive(r_rstn, r_wmem, r_addr, r_wdata, r_ack, r_mrd);
         #3;
         e_drain  = (q.size() != 0) && r_ack;
         e_accept = r_wmem && ((q.size() < DEPTH) || e_drain);
         e_stall  = r_wmem && !e_accept;
         e_rdata  = r_mrd;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == r_addr[31:2]) begin
               e_rdata = q[i].d;
               break;
            end
         end
         chk("r_stall",  {31'b0, core_stall}, {31'b0, e_stall});
         chk("r_rdata",  core_rdata, e_rdata);
         chk("r_req",    {31'b0, mem_req}, {31'b0, q.size() != 0});
         chk("r_maddr",  mem_addr,  (q.size() != 0) ? {q[0].a, 2'b00} : 32'h0);
         chk("r_mwdata", mem_wdata, (q.size() != 0) ? q[0].d : 32'h0);
         chk("r_count",  32'(count), 32'(q.size()));
         chk("r_empty",  {31'b0, empty}, {31'b0, q.size() == 0});
         @(posedge clk);
         if (!r_rstn) begin
            q.delete();
         end else begin
            if (e_drain) void'(q.pop_front());
            if (e_accept) begin
               e.a = r_addr[31:2];
               e.d = r_wdata;
               q.push_back(e);
            end
         end
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
